// File: rtl/fetch_unit_if.sv
// Instruction-memory request/ack bus between the fetch stage and the instruction source.
interface fetch_unit_if #(parameter int PC_W = 5);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic [7:0]      mem_data;
  logic            mem_ack;

  modport master (output mem_req, output mem_addr, input mem_data, input mem_ack);
  modport slave  (input mem_req, input mem_addr, output mem_data, output mem_ack);
endinterface

// File: rtl/fetch_unit.sv
// McCoy fetch stage: PC, req/ack instruction fetch, issue to decoder, branch/jump PC select.
module fetch_unit #(
  parameter int PC_W  = 5,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  fetch_unit_if.master      mem,
  output logic [2:0]        opcode,
  output logic [PC_W-1:0]   operand,
  output logic              ir_valid,
  input  logic              ex_ready,
  input  logic              bez,
  input  logic              ja,
  input  logic              x8_zero,
  output logic [PC_W-1:0]   pc,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {IDLE, FETCH, ISSUE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        ir_q, ir_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              consume;

  assign consume = (state_q == ISSUE) && ex_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= 8'h00;
      pc_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    unique case (state_q)
      IDLE:  if (run) state_d = FETCH;
      FETCH: begin
        // run is deliberately ignored here so an issued request always completes
        if (mem.mem_ack) begin
          ir_d    = mem.mem_data;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (consume) begin
          if (ja || (bez && x8_zero)) pc_d = ir_q[PC_W-1:0];
          else                        pc_d = pc_q + 1'b1;
          ret_d   = ret_q + 1'b1;
          state_d = run ? FETCH : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem.mem_req  = (state_q == FETCH);
  assign mem.mem_addr = pc_q;
  assign ir_valid     = (state_q == ISSUE);
  assign opcode       = ir_q[7:5];
  assign operand      = ir_q[PC_W-1:0];
  assign pc           = pc_q;
  assign retired      = ret_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: start-up, wait/stall, branches, wrap, run gating, reset mid-fetch.
module tb_fetch_unit;
  localparam int PC_W  = 5;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset, run, ex_ready, bez, ja, x8_zero;
  logic [2:0]       opcode;
  logic [PC_W-1:0]  operand, pc;
  logic             ir_valid;
  logic [CNT_W-1:0] retired;
  int               checks = 0;
  int               errors = 0;

  fetch_unit_if #(.PC_W(PC_W)) mem_bus ();

  fetch_unit #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .run(run), .mem(mem_bus.master),
    .opcode(opcode), .operand(operand), .ir_valid(ir_valid), .ex_ready(ex_ready),
    .bez(bez), .ja(ja), .x8_zero(x8_zero), .pc(pc), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From FETCH: ack with d, then consume with the given branch inputs.
  task automatic do_instr(input logic [7:0] d, input logic j, input logic b, input logic z);
    mem_bus.mem_data = d;
    mem_bus.mem_ack  = 1'b1;
    step();
    mem_bus.mem_ack  = 1'b0;
    ja = j; bez = b; x8_zero = z; ex_ready = 1'b1;
    step();
    ex_ready = 1'b0; ja = 1'b0; bez = 1'b0; x8_zero = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b1; ex_ready = 1'b0; bez = 1'b0; ja = 1'b0; x8_zero = 1'b0;
    mem_bus.mem_data = 8'h00; mem_bus.mem_ack = 1'b0;
    step(); step();
    chk("rst_req", mem_bus.mem_req, 0);
    chk("rst_valid", ir_valid, 0);
    chk("rst_opcode", opcode, 0);
    chk("rst_operand", operand, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);

    reset = 1'b0;
    step();
    chk("start_req", mem_bus.mem_req, 1);
    chk("start_addr", mem_bus.mem_addr, 0);
    mem_bus.mem_data = 8'h25; mem_bus.mem_ack = 1'b1;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("issue_valid", ir_valid, 1);
    chk("issue_opcode", opcode, 3'b001);
    chk("issue_operand", operand, 5);
    chk("issue_req", mem_bus.mem_req, 0);
    ex_ready = 1'b1;
    step();
    ex_ready = 1'b0;
    chk("first_pc", pc, 1);
    chk("first_retired", retired, 1);
    chk("next_req", mem_bus.mem_req, 1);
    chk("next_addr", mem_bus.mem_addr, 1);

    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_req", mem_bus.mem_req, 1);
      chk("wait_addr", mem_bus.mem_addr, 1);
    end
    mem_bus.mem_data = 8'h47; mem_bus.mem_ack = 1'b1;
    step();
    mem_bus.mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_valid", ir_valid, 1);
      chk("stall_opcode", opcode, 3'b010);
      chk("stall_operand", operand, 7);
      chk("stall_retired", retired, 1);
    end
    ex_ready = 1'b1;
    step();
    ex_ready = 1'b0;
    chk("stall_pc", pc, 2);
    chk("stall_ret", retired, 2);

    do_instr(8'h0C, 1, 0, 0); chk("ja_pc", pc, 12);
    do_instr(8'h03, 0, 1, 1); chk("bez_taken_pc", pc, 3);
    do_instr(8'h07, 1, 0, 0); chk("ja7_pc", pc, 7);
    do_instr(8'h03, 0, 1, 0); chk("bez_not_taken_pc", pc, 8);
    do_instr(8'h09, 1, 1, 0); chk("ja_prio_pc", pc, 9);
    do_instr(8'h1F, 1, 0, 0); chk("ja31_pc", pc, 31);
    do_instr(8'h00, 0, 0, 0);
    chk("wrap_pc", pc, 0);
    chk("wrap_addr", mem_bus.mem_addr, 0);
    chk("count9", retired, 9);

    for (int i = 0; i < 246; i++) do_instr(8'h00, 0, 0, 0);
    chk("count255", retired, 255);
    chk("pc22", pc, 22);
    do_instr(8'h00, 0, 0, 0);
    chk("ret_wrap", retired, 0);
    chk("pc23", pc, 23);

    mem_bus.mem_data = 8'h42; mem_bus.mem_ack = 1'b1;
    step();
    mem_bus.mem_ack = 1'b0;
    run = 1'b0; ex_ready = 1'b1;
    step();
    ex_ready = 1'b0;
    chk("idle_req", mem_bus.mem_req, 0);
    chk("idle_valid", ir_valid, 0);
    chk("idle_pc", pc, 24);
    mem_bus.mem_data = 8'hFF; mem_bus.mem_ack = 1'b1;
    step();
    mem_bus.mem_ack = 1'b0;
    chk("spur_opcode", opcode, 3'b010);
    chk("spur_operand", operand, 2);
    chk("spur_req", mem_bus.mem_req, 0);
    chk("spur_valid", ir_valid, 0);
    run = 1'b1;
    step();
    chk("resume_req", mem_bus.mem_req, 1);
    chk("resume_addr", mem_bus.mem_addr, 24);

    mem_bus.mem_data = 8'hE1; mem_bus.mem_ack = 1'b1; reset = 1'b1;
    step();
    mem_bus.mem_ack = 1'b0; reset = 1'b0; run = 1'b0;
    chk("mrst_valid", ir_valid, 0);
    chk("mrst_req", mem_bus.mem_req, 0);
    chk("mrst_opcode", opcode, 0);
    chk("mrst_operand", operand, 0);
    chk("mrst_pc", pc, 0);
    chk("mrst_retired", retired, 0);
    step();
    chk("mrst_idle_req", mem_bus.mem_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
